// File: rtl/onewire_slave_bitio_if.sv
// Bus and transfer handshake bundle between the 1-Wire slave bit engine and its client.
// The slave modport is the engine side; master is the client/bench side.
interface onewire_slave_bitio_if #(
  parameter int MAX_BITS = 8,
  parameter int NBW      = 4
);
  logic                io_i;
  logic                io_o;
  logic                od_mode;
  logic                tx_mode;
  logic                start;
  logic [NBW-1:0]      nbits;
  logic [MAX_BITS-1:0] tx_data;
  logic [MAX_BITS-1:0] rx_data;
  logic                busy;
  logic                done;
  logic                aborted;
  logic                bus_rst;
  logic                od_bus_rst;

  modport slave (
    input  io_i, od_mode, tx_mode, start, nbits, tx_data,
    output io_o, rx_data, busy, done, aborted, bus_rst, od_bus_rst
  );

  modport master (
    output io_i, od_mode, tx_mode, start, nbits, tx_data,
    input  io_o, rx_data, busy, done, aborted, bus_rst, od_bus_rst
  );
endinterface

// File: rtl/onewire_slave_bitio.sv
// 1-Wire slave bit/byte engine: filtered bus sampling, us timers, LSB-first
// rx/tx of 1..MAX_BITS bits, reset/overdrive-reset detection and presence pulse.
module onewire_slave_bitio #(
  parameter int CLK_HZ   = 50000000,
  parameter int FILT_LEN = 3,
  parameter int MAX_BITS = 8,
  parameter int NBW      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  onewire_slave_bitio_if.slave  bif
);

  localparam int TICK_DIV = CLK_HZ / 1000000;
  localparam int DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW       = $clog2(FILT_LEN + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_FALL = 3'd1,
    TX_LOW    = 3'd2,
    WAIT_RISE = 3'd3,
    PRES_WAIT = 3'd4,
    PRES_LOW  = 3'd5
  } state_t;

  state_t              state_r, state_nx;
  logic [DW-1:0]       div_r;
  logic                tick_s;
  logic [1:0]          sync_r;
  logic [FW-1:0]       filt_cnt_r;
  logic                bus_r, fall_r, rise_r;
  logic [9:0]          low_us_r, high_us_r, slot_us_r;
  logic                io_r, io_nx;
  logic                busy_r, busy_nx;
  logic                done_r, done_nx;
  logic                aborted_r, aborted_nx;
  logic                bus_rst_r, bus_rst_nx;
  logic                od_bus_rst_r, od_bus_rst_nx;
  logic [MAX_BITS-1:0] rx_r, rx_nx;
  logic [MAX_BITS-1:0] txd_r, txd_nx;
  logic [NBW-1:0]      idx_r, idx_nx;
  logic [NBW-1:0]      nb_r, nb_nx;
  logic                od_l_r, od_l_nx;
  logic                tx_l_r, tx_l_nx;
  logic                pres_od_r, pres_od_nx;
  logic [NBW-1:0]      nbits_cl_s;
  logic                det_ok_s, std_det_s, od_det_s;
  logic                rx_bit_s, pres_enter_s;

  assign tick_s       = (div_r == DW'(TICK_DIV - 1));
  assign nbits_cl_s   = (bif.nbits > NBW'(MAX_BITS)) ? NBW'(MAX_BITS) : bif.nbits;
  // own presence low must never be mistaken for a master reset
  assign det_ok_s     = rise_r && (state_r != PRES_LOW);
  assign std_det_s    = det_ok_s && (low_us_r >= 10'd400);
  assign od_det_s     = det_ok_s && !std_det_s && bif.od_mode &&
                        (low_us_r >= 10'd40) && (low_us_r < 10'd90);
  assign rx_bit_s     = od_l_r ? (low_us_r < 10'd2) : (low_us_r < 10'd15);
  assign pres_enter_s = (state_nx == PRES_LOW) && (state_r != PRES_LOW);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_r <= '0;
    end else if (tick_s) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DW'(1);
    end
  end

  // a level change is accepted only after FILT_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r     <= 2'b11;
      filt_cnt_r <= '0;
      bus_r      <= 1'b1;
      fall_r     <= 1'b0;
      rise_r     <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], bif.io_i};
      fall_r <= 1'b0;
      rise_r <= 1'b0;
      if (sync_r[1] == bus_r) begin
        filt_cnt_r <= '0;
      end else if (filt_cnt_r == FW'(FILT_LEN - 1)) begin
        filt_cnt_r <= '0;
        bus_r      <= sync_r[1];
        fall_r     <= ~sync_r[1];
        rise_r     <= sync_r[1];
      end else begin
        filt_cnt_r <= filt_cnt_r + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      low_us_r  <= 10'd0;
      high_us_r <= 10'd0;
      slot_us_r <= 10'd0;
    end else begin
      if (fall_r) begin
        low_us_r <= 10'd0;
      end else if (tick_s && !bus_r && (low_us_r != 10'h3FF)) begin
        low_us_r <= low_us_r + 10'd1;
      end
      if (rise_r) begin
        high_us_r <= 10'd0;
      end else if (tick_s && bus_r && (high_us_r != 10'h3FF)) begin
        high_us_r <= high_us_r + 10'd1;
      end
      // presence length is timed from our own drive, not from the master's reset fall
      if (fall_r || pres_enter_s) begin
        slot_us_r <= 10'd0;
      end else if (tick_s && (state_r != IDLE) && (slot_us_r != 10'h3FF)) begin
        slot_us_r <= slot_us_r + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      io_r         <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      aborted_r    <= 1'b0;
      bus_rst_r    <= 1'b0;
      od_bus_rst_r <= 1'b0;
      rx_r         <= '0;
      txd_r        <= '0;
      idx_r        <= '0;
      nb_r         <= '0;
      od_l_r       <= 1'b0;
      tx_l_r       <= 1'b0;
      pres_od_r    <= 1'b0;
    end else begin
      state_r      <= state_nx;
      io_r         <= io_nx;
      busy_r       <= busy_nx;
      done_r       <= done_nx;
      aborted_r    <= aborted_nx;
      bus_rst_r    <= bus_rst_nx;
      od_bus_rst_r <= od_bus_rst_nx;
      rx_r         <= rx_nx;
      txd_r        <= txd_nx;
      idx_r        <= idx_nx;
      nb_r         <= nb_nx;
      od_l_r       <= od_l_nx;
      tx_l_r       <= tx_l_nx;
      pres_od_r    <= pres_od_nx;
    end
  end

  always_comb begin
    state_nx      = state_r;
    io_nx         = 1'b1;
    busy_nx       = busy_r;
    done_nx       = 1'b0;
    aborted_nx    = 1'b0;
    bus_rst_nx    = 1'b0;
    od_bus_rst_nx = 1'b0;
    rx_nx         = rx_r;
    txd_nx        = txd_r;
    idx_nx        = idx_r;
    nb_nx         = nb_r;
    od_l_nx       = od_l_r;
    tx_l_nx       = tx_l_r;
    pres_od_nx    = pres_od_r;
    if (std_det_s || od_det_s) begin
      bus_rst_nx    = std_det_s;
      od_bus_rst_nx = od_det_s;
      pres_od_nx    = od_det_s;
      done_nx       = busy_r;
      aborted_nx    = busy_r;
      busy_nx       = 1'b0;
      state_nx      = PRES_WAIT;
    end else begin
      case (state_r)
        IDLE: begin
          if (bif.start && !busy_r) begin
            nb_nx   = nbits_cl_s;
            txd_nx  = bif.tx_data;
            od_l_nx = bif.od_mode;
            tx_l_nx = bif.tx_mode;
            rx_nx   = '0;
            idx_nx  = '0;
            if (nbits_cl_s == '0) begin
              done_nx = 1'b1;
            end else begin
              busy_nx  = 1'b1;
              state_nx = WAIT_FALL;
            end
          end else begin
            state_nx = IDLE;
          end
        end
        WAIT_FALL: begin
          if (fall_r) begin
            if (tx_l_r && !txd_r[0]) begin
              io_nx    = 1'b0;
              state_nx = TX_LOW;
            end else begin
              state_nx = WAIT_RISE;
            end
          end else begin
            state_nx = WAIT_FALL;
          end
        end
        TX_LOW: begin
          if (slot_us_r >= (od_l_r ? 10'd3 : 10'd30)) begin
            state_nx = WAIT_RISE;
          end else begin
            io_nx = 1'b0;
          end
        end
        WAIT_RISE: begin
          if (rise_r) begin
            if (!tx_l_r) begin
              for (int i = 0; i < MAX_BITS; i++) begin
                rx_nx[i] = (idx_r == NBW'(i)) ? rx_bit_s : rx_r[i];
              end
            end else begin
              rx_nx = rx_r;
            end
            txd_nx = txd_r >> 1;
            idx_nx = idx_r + NBW'(1);
            if ((idx_r + NBW'(1)) == nb_r) begin
              done_nx  = 1'b1;
              busy_nx  = 1'b0;
              state_nx = IDLE;
            end else begin
              state_nx = WAIT_FALL;
            end
          end else begin
            state_nx = WAIT_RISE;
          end
        end
        PRES_WAIT: begin
          if (fall_r) begin
            state_nx = IDLE;
          end else if (high_us_r >= (pres_od_r ? 10'd3 : 10'd20)) begin
            io_nx    = 1'b0;
            state_nx = PRES_LOW;
          end else begin
            state_nx = PRES_WAIT;
          end
        end
        PRES_LOW: begin
          if (slot_us_r >= (pres_od_r ? 10'd10 : 10'd120)) begin
            state_nx = IDLE;
          end else begin
            io_nx = 1'b0;
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  assign bif.io_o       = io_r;
  assign bif.busy       = busy_r;
  assign bif.done       = done_r;
  assign bif.aborted    = aborted_r;
  assign bif.bus_rst    = bus_rst_r;
  assign bif.od_bus_rst = od_bus_rst_r;
  assign bif.rx_data    = rx_r;

endmodule

// File: tb/tb_onewire_slave_bitio.sv
// Directed bench for onewire_slave_bitio: a wired-AND master model drives the bus
// with slot timings in microseconds (10 clocks per us).
`timescale 1ns/1ps
module tb_onewire_slave_bitio;

  localparam int US = 10;

  logic clk = 1'b0;
  logic rst;
  logic master_drv;
  int   checks = 0;
  int   failures = 0;

  int   done_cnt = 0, bus_rst_cnt = 0, od_rst_cnt = 0, rst_abort_cnt = 0;
  logic last_aborted = 1'b0;

  onewire_slave_bitio_if #(.MAX_BITS(8), .NBW(4)) bif ();

  onewire_slave_bitio #(.CLK_HZ(10000000), .FILT_LEN(3), .MAX_BITS(8), .NBW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  assign bif.io_i = master_drv & bif.io_o;

  always #5 clk = ~clk;

  // pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (bif.done === 1'b1) begin
      done_cnt     = done_cnt + 1;
      last_aborted = bif.aborted;
    end
    if (bif.bus_rst === 1'b1) bus_rst_cnt = bus_rst_cnt + 1;
    if (bif.od_bus_rst === 1'b1) od_rst_cnt = od_rst_cnt + 1;
    if (bif.bus_rst === 1'b1 && bif.done === 1'b1 && bif.aborted === 1'b1)
      rst_abort_cnt = rst_abort_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks = checks + 1;
    assert (obs >= lo && obs <= hi) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic tx, input logic od, input logic [3:0] n, input logic [7:0] d);
    bif.tx_mode = tx;
    bif.od_mode = od;
    bif.nbits   = n;
    bif.tx_data = d;
    bif.start   = 1'b1;
    step(1);
    bif.start   = 1'b0;
  endtask

  // one master slot; returns the number of cycles the DUT pulled the bus low
  task automatic slot(input int low_us, input int tot_us, output int drv);
    drv = 0;
    for (int i = 0; i < tot_us * US; i++) begin
      master_drv = (i < low_us * US) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (bif.io_o === 1'b0) drv = drv + 1;
      @(posedge clk);
      #1;
    end
    master_drv = 1'b1;
  endtask

  task automatic measure_presence(output int dly, output int len);
    dly = 0;
    while (bif.io_o !== 1'b0 && dly < 5000) begin
      step(1);
      dly = dly + 1;
    end
    len = 0;
    while (bif.io_o !== 1'b1 && len < 5000) begin
      step(1);
      len = len + 1;
    end
  endtask

  initial begin
    int drv, sum, d0, b0, o0, ra0, dly, len;
    logic [7:0] pat;

    rst         = 1'b1;
    master_drv  = 1'b1;
    bif.od_mode = 1'b0;
    bif.tx_mode = 1'b0;
    bif.start   = 1'b0;
    bif.nbits   = 4'd0;
    bif.tx_data = 8'h00;
    step(5);
    chk("rst_io_o", {31'd0, bif.io_o}, 32'd1);
    chk("rst_rx_data", {24'd0, bif.rx_data}, 32'd0);
    chk("rst_busy", {31'd0, bif.busy}, 32'd0);
    chk("rst_done", {31'd0, bif.done}, 32'd0);
    chk("rst_aborted", {31'd0, bif.aborted}, 32'd0);
    chk("rst_bus_rst", {31'd0, bif.bus_rst}, 32'd0);
    chk("rst_od_bus_rst", {31'd0, bif.od_bus_rst}, 32'd0);
    rst = 1'b0;
    step(20);

    // std rx of 0xA5: 6us lows are ones, 60us lows are zeros
    d0 = done_cnt;
    do_start(1'b0, 1'b0, 4'd8, 8'h00);
    chk("rx_busy_after_start", {31'd0, bif.busy}, 32'd1);
    pat = 8'hA5;
    sum = 0;
    for (int b = 0; b < 8; b++) begin
      if (b == 7) chk("rx_no_done_before_8th", done_cnt - d0, 32'd0);
      slot(pat[b] ? 6 : 60, 70, drv);
      sum = sum + drv;
    end
    chk("rx_done_count", done_cnt - d0, 32'd1);
    chk("rx_aborted", {31'd0, last_aborted}, 32'd0);
    chk("rx_data_A5", {24'd0, bif.rx_data}, 32'hA5);
    chk("rx_never_drives", sum, 32'd0);
    chk("rx_busy_end", {31'd0, bif.busy}, 32'd0);
    step(20 * US);

    // std tx of 0x3C: zero bits held low ~30us, one bits never driven
    d0 = done_cnt;
    do_start(1'b1, 1'b0, 4'd8, 8'h3C);
    pat = 8'h3C;
    for (int b = 0; b < 8; b++) begin
      if (b == 7) chk("tx_no_done_before_8th", done_cnt - d0, 32'd0);
      slot(6, 70, drv);
      if (pat[b]) chk_rng($sformatf("tx_bit%0d_released", b), drv, 0, 0);
      else        chk_rng($sformatf("tx_bit%0d_low30", b), drv, 28 * US, 31 * US);
    end
    chk("tx_done_count", done_cnt - d0, 32'd1);
    chk("tx_aborted", {31'd0, last_aborted}, 32'd0);
    step(20 * US);

    // nbits=0: immediate done, no bus activity
    d0 = done_cnt;
    do_start(1'b0, 1'b0, 4'd0, 8'h00);
    chk("n0_done_next", {31'd0, bif.done}, 32'd1);
    chk("n0_busy", {31'd0, bif.busy}, 32'd0);
    step(1);
    chk("n0_done_one_cycle", {31'd0, bif.done}, 32'd0);
    step(10);

    // od tx of two bits 2'b01 with 1us master lows
    d0 = done_cnt;
    do_start(1'b1, 1'b1, 4'd2, 8'h01);
    slot(1, 10, drv);
    chk_rng("od_tx_slot0_released", drv, 0, 0);
    chk("od_tx_no_done_after_1", done_cnt - d0, 32'd0);
    slot(1, 10, drv);
    chk_rng("od_tx_slot1_low3", drv, 18, 33);
    chk("od_tx_done_count", done_cnt - d0, 32'd1);
    chk("od_tx_aborted", {31'd0, last_aborted}, 32'd0);
    step(10 * US);

    // overdrive reset: 60us low, then 3us wait and 10us presence; idle so no done
    d0 = done_cnt; b0 = bus_rst_cnt; o0 = od_rst_cnt;
    slot(60, 60, drv);
    measure_presence(dly, len);
    chk("odr_pulse", od_rst_cnt - o0, 32'd1);
    chk("odr_no_std", bus_rst_cnt - b0, 32'd0);
    chk("odr_no_done_idle", done_cnt - d0, 32'd0);
    chk_rng("odr_pres_delay", dly, 22, 42);
    chk_rng("odr_pres_len", len, 92, 115);
    step(20 * US);
    o0 = od_rst_cnt;
    slot(30, 60, drv);
    chk("od_30us_no_odr", od_rst_cnt - o0, 32'd0);
    chk("od_30us_no_rst", bus_rst_cnt - b0, 32'd0);
    chk_rng("od_30us_no_presence", drv, 0, 0);
    step(20 * US);

    // 500us master low during bit 3 of an rx transfer
    d0 = done_cnt; b0 = bus_rst_cnt; ra0 = rst_abort_cnt;
    do_start(1'b0, 1'b0, 4'd8, 8'h00);
    slot(6, 70, drv);
    slot(60, 70, drv);
    slot(6, 70, drv);
    slot(500, 500, drv);
    measure_presence(dly, len);
    chk("rst_pulse", bus_rst_cnt - b0, 32'd1);
    chk("rst_abort_same_cycle", rst_abort_cnt - ra0, 32'd1);
    chk("rst_done_count", done_cnt - d0, 32'd1);
    chk("rst_busy_cleared", {31'd0, bif.busy}, 32'd0);
    chk("rst_rx_kept", {24'd0, bif.rx_data}, 32'h05);
    chk_rng("rst_pres_delay", dly, 190, 215);
    chk_rng("rst_pres_len", len, 1185, 1225);
    step(30 * US);

    // 1- and 2-cycle glitches must not register as slots
    d0 = done_cnt;
    do_start(1'b0, 1'b0, 4'd1, 8'h00);
    for (int g = 0; g < 4; g++) begin
      master_drv = 1'b0;
      step((g % 2) + 1);
      master_drv = 1'b1;
      step(20);
    end
    chk("glitch_busy", {31'd0, bif.busy}, 32'd1);
    chk("glitch_no_done", done_cnt - d0, 32'd0);
    chk("glitch_rx_zero", {24'd0, bif.rx_data}, 32'd0);
    slot(6, 70, drv);
    chk("glitch_then_done", done_cnt - d0, 32'd1);
    chk("glitch_then_rx", {24'd0, bif.rx_data}, 32'h01);
    step(10 * US);

    // synchronous reset while holding a tx-0 low
    do_start(1'b1, 1'b0, 4'd1, 8'h00);
    master_drv = 1'b0;
    step(US);
    master_drv = 1'b1;
    step(10 * US);
    chk("txlow_driving", {31'd0, bif.io_o}, 32'd0);
    rst = 1'b1;
    step(1);
    chk("txlow_rst_io_o", {31'd0, bif.io_o}, 32'd1);
    chk("txlow_rst_busy", {31'd0, bif.busy}, 32'd0);
    rst = 1'b0;
    step(50 * US);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
